// File: rtl/spu32_wb8_arbiter_pkg.sv
// Shared definitions for the spu32 8-bit Wishbone two-master arbiter.
// Holds the arbiter state encoding, the GRANT encoding and the master id
// constants used for the round-robin memory.
package spu32_wb8_arbiter_pkg;

    localparam int unsigned DAT_WIDTH   = 8;
    localparam int unsigned GRANT_WIDTH = 2;

    // The state codes double as the one-hot GRANT value of the owner.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_t;

    localparam logic [GRANT_WIDTH-1:0] GRANT_NONE = 2'b00;
    localparam logic [GRANT_WIDTH-1:0] GRANT_M0   = 2'b01;
    localparam logic [GRANT_WIDTH-1:0] GRANT_M1   = 2'b10;

    // Encoding of the last_owner bit.
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // One-hot grant for a state; IDLE and any illegal code map to no owner.
    function automatic logic [GRANT_WIDTH-1:0] grant_of(input arb_state_t s);
        logic [GRANT_WIDTH-1:0] g;
        g = GRANT_NONE;
        case (s)
            ARB_OWN0: g = GRANT_M0;
            ARB_OWN1: g = GRANT_M1;
            default:  g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/spu32_wb8_arbiter_pick.sv
// Combinational round-robin pick for the two-master arbiter.
// Ports:
//   req0, req1  : CYC requests of master 0 / master 1
//   last_owner  : master that owned the bus most recently (OWNER_M0/OWNER_M1)
//   pick        : state the arbiter should enter (IDLE, OWN0 or OWN1)
module spu32_wb8_arbiter_pick
    import spu32_wb8_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    output arb_state_t pick
);

    // On contention the master that did not own the bus last goes first.
    always_comb begin
        pick = ARB_IDLE;
        if (req0 && req1) begin
            pick = (last_owner == OWNER_M0) ? ARB_OWN1 : ARB_OWN0;
        end else if (req0) begin
            pick = ARB_OWN0;
        end else if (req1) begin
            pick = ARB_OWN1;
        end
    end

endmodule

// File: rtl/spu32_wb8_arbiter.sv
// Two-master, one-slave arbiter for the spu32 8-bit pipelined Wishbone bus.
// Ownership is granted per bus cycle (CYC interval) and is never preempted;
// contention is resolved round-robin. The grant is a registered state; the
// slave/master muxes are combinational from it, so an asynchronous reset
// removes CYC/STB/WE from the slave immediately.
// Ports:
//   CLK_I, RST_N_I             : clock, asynchronous active-low reset
//   M0_*_I / M0_*_O            : master 0 (CPU) request inputs, ACK/STALL/DAT
//   M1_*_I / M1_*_O            : master 1 (DMA) request inputs, ACK/STALL/DAT
//   S_*_O / S_*_I              : slave request outputs, ACK/STALL/DAT inputs
//   GRANT_O                    : one-hot current owner, 2'b00 when idle
module spu32_wb8_arbiter
    import spu32_wb8_arbiter_pkg::*;
#(
    parameter int unsigned ADR_WIDTH     = 32,
    parameter int unsigned PRIO_M0_FIRST = 1
) (
    input  logic                   CLK_I,
    input  logic                   RST_N_I,

    input  logic [ADR_WIDTH-1:0]   M0_ADR_I,
    input  logic [DAT_WIDTH-1:0]   M0_DAT_I,
    input  logic                   M0_CYC_I,
    input  logic                   M0_STB_I,
    input  logic                   M0_WE_I,
    output logic                   M0_ACK_O,
    output logic                   M0_STALL_O,
    output logic [DAT_WIDTH-1:0]   M0_DAT_O,

    input  logic [ADR_WIDTH-1:0]   M1_ADR_I,
    input  logic [DAT_WIDTH-1:0]   M1_DAT_I,
    input  logic                   M1_CYC_I,
    input  logic                   M1_STB_I,
    input  logic                   M1_WE_I,
    output logic                   M1_ACK_O,
    output logic                   M1_STALL_O,
    output logic [DAT_WIDTH-1:0]   M1_DAT_O,

    output logic [ADR_WIDTH-1:0]   S_ADR_O,
    output logic [DAT_WIDTH-1:0]   S_DAT_O,
    output logic                   S_CYC_O,
    output logic                   S_STB_O,
    output logic                   S_WE_O,
    input  logic                   S_ACK_I,
    input  logic                   S_STALL_I,
    input  logic [DAT_WIDTH-1:0]   S_DAT_I,

    output logic [GRANT_WIDTH-1:0] GRANT_O
);

    // Reset value makes the first contention go to the preferred master.
    localparam logic LAST_OWNER_RST = (PRIO_M0_FIRST != 0) ? OWNER_M1 : OWNER_M0;

    arb_state_t state;
    arb_state_t state_nxt;
    arb_state_t pick;
    logic       last_owner;
    logic       last_owner_nxt;

    spu32_wb8_arbiter_pick u_pick (
        .req0       (M0_CYC_I),
        .req1       (M1_CYC_I),
        .last_owner (last_owner),
        .pick       (pick)
    );

    // State and round-robin memory.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state      <= ARB_IDLE;
            last_owner <= LAST_OWNER_RST;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Next state: an owner keeps the bus until its own CYC falls.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            ARB_IDLE: begin
                state_nxt = pick;
            end
            ARB_OWN0: begin
                if (!M0_CYC_I) begin
                    state_nxt      = pick;
                    last_owner_nxt = OWNER_M0;
                end
            end
            ARB_OWN1: begin
                if (!M1_CYC_I) begin
                    state_nxt      = pick;
                    last_owner_nxt = OWNER_M1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Owner routing; non-owners see STALL=1 and never an ACK.
    always_comb begin
        S_ADR_O    = '0;
        S_DAT_O    = '0;
        S_CYC_O    = 1'b0;
        S_STB_O    = 1'b0;
        S_WE_O     = 1'b0;
        M0_ACK_O   = 1'b0;
        M0_STALL_O = 1'b1;
        M1_ACK_O   = 1'b0;
        M1_STALL_O = 1'b1;
        GRANT_O    = grant_of(state);
        case (state)
            ARB_OWN0: begin
                S_ADR_O    = M0_ADR_I;
                S_DAT_O    = M0_DAT_I;
                S_CYC_O    = M0_CYC_I;
                S_STB_O    = M0_STB_I & M0_CYC_I;
                S_WE_O     = M0_WE_I;
                M0_ACK_O   = S_ACK_I;
                M0_STALL_O = S_STALL_I;
            end
            ARB_OWN1: begin
                S_ADR_O    = M1_ADR_I;
                S_DAT_O    = M1_DAT_I;
                S_CYC_O    = M1_CYC_I;
                S_STB_O    = M1_STB_I & M1_CYC_I;
                S_WE_O     = M1_WE_I;
                M1_ACK_O   = S_ACK_I;
                M1_STALL_O = S_STALL_I;
            end
            default: begin
                // IDLE: nothing forwarded, late slave ACKs are dropped.
            end
        endcase
    end

    // Read data is broadcast; only the owner gets the qualifying ACK.
    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;

endmodule

// File: tb/tb_spu32_wb8_arbiter.sv
// Self-checking bench for spu32_wb8_arbiter: two master tasks, a pipelined
// slave with 2-cycle ACK latency, per-master scoreboards of expected read
// data and a compressed GRANT trace for ordering checks.
module tb_spu32_wb8_arbiter;

    logic        clk;
    logic        rst_n;

    logic [31:0] m_adr [2];
    logic [7:0]  m_dat [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];

    logic        m0_ack, m0_stall, m1_ack, m1_stall;
    logic [7:0]  m0_rdat, m1_rdat;
    logic [31:0] s_adr;
    logic [7:0]  s_wdat, s_rdat;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [1:0]  grant;

    spu32_wb8_arbiter #(.ADR_WIDTH(32), .PRIO_M0_FIRST(1)) dut (
        .CLK_I      (clk),
        .RST_N_I    (rst_n),
        .M0_ADR_I   (m_adr[0]),
        .M0_DAT_I   (m_dat[0]),
        .M0_CYC_I   (m_cyc[0]),
        .M0_STB_I   (m_stb[0]),
        .M0_WE_I    (m_we[0]),
        .M0_ACK_O   (m0_ack),
        .M0_STALL_O (m0_stall),
        .M0_DAT_O   (m0_rdat),
        .M1_ADR_I   (m_adr[1]),
        .M1_DAT_I   (m_dat[1]),
        .M1_CYC_I   (m_cyc[1]),
        .M1_STB_I   (m_stb[1]),
        .M1_WE_I    (m_we[1]),
        .M1_ACK_O   (m1_ack),
        .M1_STALL_O (m1_stall),
        .M1_DAT_O   (m1_rdat),
        .S_ADR_O    (s_adr),
        .S_DAT_O    (s_wdat),
        .S_CYC_O    (s_cyc),
        .S_STB_O    (s_stb),
        .S_WE_O     (s_we),
        .S_ACK_I    (s_ack),
        .S_STALL_I  (s_stall),
        .S_DAT_I    (s_rdat),
        .GRANT_O    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    bit          abort = 0;
    time         last_ack_t  [2];
    time         first_acc_t [2];
    bit          trace_on = 0;
    logic [23:0] trace_word = '0;
    int          trace_len = 0;
    logic [1:0]  trace_last = '0;
    logic        extra_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave: accepts STB when not stalling, ACKs two edges later with
    // data = adr[7:0] ^ 0x91. Stalls odd cycles for addresses 0x1xx.
    logic       p1_v, p2_v;
    logic [7:0] p1_d, p2_d;
    logic [7:0] cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v    <= 1'b0;
            p2_v    <= 1'b0;
            p1_d    <= '0;
            p2_d    <= '0;
            cyc_cnt <= '0;
        end else begin
            p1_v    <= s_stb && !s_stall;
            p1_d    <= s_adr[7:0] ^ 8'h91;
            p2_v    <= p1_v;
            p2_d    <= p1_d;
            cyc_cnt <= cyc_cnt + 8'd1;
        end
    end

    assign s_ack   = p2_v | extra_ack;
    assign s_rdat  = p2_d;
    assign s_stall = (s_adr[11:8] == 4'h1) && cyc_cnt[0];

    // ACK monitor against scoreboards, plus GRANT trace (duplicates merged).
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_ack) begin
                if (q0.size() == 0) check_eq("m0_unexpected_ack", 32'(m0_ack), 32'(0));
                else check_eq("m0_rdata", 32'(m0_rdat), 32'(q0.pop_front()));
            end
            if (m1_ack) begin
                if (q1.size() == 0) check_eq("m1_unexpected_ack", 32'(m1_ack), 32'(0));
                else check_eq("m1_rdata", 32'(m1_rdat), 32'(q1.pop_front()));
            end
        end
        if (trace_on && (trace_len == 0 || trace_last != grant)) begin
            trace_word = {trace_word[21:0], grant};
            trace_len++;
            trace_last = grant;
        end
    end

    // One bus cycle of n consecutive strobes from master m; keeps CYC until
    // all ACKs arrive, then stays released for one cycle.
    task automatic master_burst(input int m, input logic [31:0] base, input int n, input logic we);
        int   issued = 0;
        int   acked  = 0;
        int   cycles = 0;
        logic stall, ack, acc;
        m_adr[m] = base;
        m_dat[m] = base[7:0] ^ 8'h3C;
        m_we[m]  = we;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        while (acked < n && cycles < 200 && !abort) begin
            @(negedge clk);
            stall = (m == 0) ? m0_stall : m1_stall;
            ack   = (m == 0) ? m0_ack   : m1_ack;
            acc   = m_stb[m] && !stall;
            if (ack) begin
                acked++;
                last_ack_t[m] = $time;
            end
            if (acc) begin
                check_eq("fwd_adr", s_adr, m_adr[m]);
                check_eq("fwd_we", 32'(s_we), 32'(m_we[m]));
                if (m_we[m]) check_eq("fwd_dat", 32'(s_wdat), 32'(m_dat[m]));
                if (m == 0) q0.push_back(m_adr[m][7:0] ^ 8'h91);
                else        q1.push_back(m_adr[m][7:0] ^ 8'h91);
                if (issued == 0) first_acc_t[m] = $time;
                issued++;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                if (issued < n) begin
                    m_adr[m] = base + 32'(issued);
                    m_dat[m] = m_adr[m][7:0] ^ 8'h3C;
                end else begin
                    m_stb[m] = 1'b0;
                end
            end
        end
        if (!abort) check_eq($sformatf("burst_done_m%0d", m), 32'(acked), 32'(n));
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        abort = 0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic trace_start();
        trace_word = '0;
        trace_len  = 0;
        trace_on   = 1;
    endtask

    task automatic trace_check(input string tag, input logic [23:0] exp_word, input int exp_len);
        repeat (2) @(posedge clk);
        #1;
        trace_on = 0;
        check_eq({tag, "_grants"}, 32'(trace_word), 32'(exp_word));
        check_eq({tag, "_len"}, 32'(trace_len), 32'(exp_len));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0;
            m_dat[i] = '0;
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
            m_we[i]  = 1'b0;
        end

        // Reset holds everything idle even with a pending request.
        rst_n    = 1'b0;
        m_cyc[0] = 1'b1;
        m_adr[0] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 32'(2'b00));
        check_eq("rst_s_cyc", 32'(s_cyc), 32'(0));
        check_eq("rst_s_stb", 32'(s_stb), 32'(0));
        check_eq("rst_s_we", 32'(s_we), 32'(0));
        check_eq("rst_s_adr", s_adr, 32'h0);
        check_eq("rst_m0_stall", 32'(m0_stall), 32'(1));
        check_eq("rst_m1_stall", 32'(m1_stall), 32'(1));
        check_eq("rst_m0_ack", 32'(m0_ack), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_grant", 32'(grant), 32'(2'b01));
        check_eq("post_rst_s_cyc", 32'(s_cyc), 32'(1));
        check_eq("post_rst_s_adr", s_adr, 32'hDEAD_BEEF);
        m_cyc[0] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("release_grant", 32'(grant), 32'(2'b00));

        // Late ACK while idle reaches nobody.
        extra_ack = 1'b1;
        #1;
        check_eq("idle_ack_m0", 32'(m0_ack), 32'(0));
        check_eq("idle_ack_m1", 32'(m1_ack), 32'(0));
        extra_ack = 1'b0;

        // Single master read: 0x1234 returns 0xA5 to M1 only.
        master_burst(1, 32'h0000_1234, 1, 1'b0);
        check_eq("single_sb_empty", 32'(q1.size()), 32'(0));

        // Contention from IDLE right after reset: M0 first, then M1.
        do_reset();
        trace_start();
        fork
            master_burst(0, 32'h0000_0200, 1, 1'b0);
            master_burst(1, 32'h0000_0300, 1, 1'b0);
        join
        trace_check("contention", 24'h000018, 4);
        check_eq("contention_handover", 32'(first_acc_t[1] - last_ack_t[0]), 32'd20);

        // No preemption: M0 4-strobe burst with slave stalls, M1 asks later.
        trace_start();
        fork
            master_burst(0, 32'h0000_0100, 4, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                master_burst(1, 32'h0000_0280, 2, 1'b1);
            end
        join
        trace_check("nopreempt", 24'h000018, 4);
        check_eq("nopreempt_handover", 32'(first_acc_t[1] - last_ack_t[0]), 32'd20);

        // Fairness: both masters re-request back to back, grants alternate.
        trace_start();
        fork
            repeat (3) master_burst(0, 32'h0000_0500, 1, 1'b0);
            repeat (3) master_burst(1, 32'h0000_0600, 1, 1'b1);
        join
        trace_check("fair", 24'h001998, 8);
        check_eq("fair_sb_empty", 32'(q0.size() + q1.size()), 32'(0));

        // Asynchronous reset between edges during an M1 write burst.
        fork
            master_burst(1, 32'h0000_0700, 6, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #3;
                check_eq("pre_arst_s_we", 32'(s_we), 32'(1));
                rst_n = 1'b0;
                #1;
                check_eq("arst_s_cyc", 32'(s_cyc), 32'(0));
                check_eq("arst_s_stb", 32'(s_stb), 32'(0));
                check_eq("arst_s_we", 32'(s_we), 32'(0));
                check_eq("arst_grant", 32'(grant), 32'(2'b00));
                check_eq("arst_m1_stall", 32'(m1_stall), 32'(1));
                abort = 1;
            end
        join
        do_reset();
        @(posedge clk);
        #1;
        check_eq("final_idle_grant", 32'(grant), 32'(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spu32_wb8_arbiter.md
Name: spu32_wb8_arbiter

Overview:
- Two-master, one-slave arbiter for the 8-bit pipelined Wishbone bus driven by the spu32 CPU bus unit.
- Lets a second requester (DMA/video fetch) share the memory port with the CPU.
- Ownership is granted per bus cycle (CYC high interval), never per strobe. Round-robin on contention.
- Sits between the CPU/DMA master ports and the memory/peripheral decoder.

Parameters:
ADR_WIDTH, 32, address width of all ports
PRIO_M0_FIRST, 1, on the first contention after reset M0 (CPU) wins when 1, M1 when 0

Ports:
CLK_I  in  1  clock, all state updates on rising edge
RST_N_I  in  1  asynchronous active-low reset
M0_ADR_I  in  ADR_WIDTH  master 0 (CPU) address
M0_DAT_I  in  8  master 0 write data
M0_CYC_I  in  1  master 0 bus cycle request
M0_STB_I  in  1  master 0 strobe
M0_WE_I  in  1  master 0 write enable
M0_ACK_O  out  1  ACK routed to master 0
M0_STALL_O  out  1  STALL routed to master 0
M0_DAT_O  out  8  read data to master 0
M1_ADR_I, M1_DAT_I, M1_CYC_I, M1_STB_I, M1_WE_I, M1_ACK_O, M1_STALL_O, M1_DAT_O  same as M0, master 1 (DMA)
S_ADR_O  out  ADR_WIDTH  slave address
S_DAT_O  out  8  slave write data
S_CYC_O  out  1  slave cycle
S_STB_O  out  1  slave strobe
S_WE_O  out  1  slave write enable
S_ACK_I  in  1  slave acknowledge
S_STALL_I  in  1  slave stall
S_DAT_I  in  8  slave read data
GRANT_O  out  2  one-hot current owner, 2'b00 when idle

Behaviour:
- Clock/reset: one clock (CLK_I); reset is asynchronous and active-low (RST_N_I). While RST_N_I=0:
  - state=IDLE; last_owner = PRIO_M0_FIRST ? M1 : M0.
  - GRANT_O=00; S_CYC_O=S_STB_O=S_WE_O=0.
  - Mx_ACK_O=0; Mx_STALL_O=1.
- Reset asserted mid-cycle drops S_CYC_O immediately (combinational from state).
- States: IDLE, OWN0, OWN1. The grant is registered. The output muxes are combinational from the registered state.
- Next-owner rule (pick):
  - only M0_CYC_I high -> OWN0
  - only M1_CYC_I high -> OWN1
  - both high -> the master that is not last_owner
  - neither -> IDLE
- IDLE: apply pick at each rising edge.
- OWNx while Mx_CYC_I=1: remain in OWNx. The other master's request never preempts.
- OWNx when Mx_CYC_I=0: apply pick at that edge, so handover to the waiting master takes 1 cycle. last_owner <= x on leaving OWNx.
- Grant latency:
  - A request arriving in IDLE is owned the next edge.
  - The first strobe can reach the slave in that same cycle (the request cycle itself is stalled).
- Owner routing:
  - S_ADR_O/S_DAT_O/S_WE_O = owner's inputs; all zero in IDLE.
  - S_CYC_O = owner's CYC; S_STB_O = owner's STB & owner's CYC.
- Masters:
  - Owner: Mx_ACK_O=S_ACK_I, Mx_STALL_O=S_STALL_I.
  - Non-owner: ACK=0, STALL=1.
  - Mx_DAT_O=S_DAT_I for both masters (broadcast). Non-owners ignore it because they receive no ACK.
- Pipelined Wishbone: masters keep CYC high until all ACKs for issued strobes have arrived. The arbiter does not count outstanding ACKs, but it must not change owner while owner CYC=1. Late S_ACK_I in IDLE is dropped.
- A non-owner STB is held off via STALL; its address/data are not forwarded.
- Simultaneous release and re-request by the same owner (CYC low for exactly one cycle) with the other master waiting: the other master wins.

Decomposition:
- Shared package/include (alongside the existing bus op defines): ARB_IDLE/ARB_OWN0/ARB_OWN1 state constants and the GRANT encoding.
- One natural sub-module: spu32_wb8_arbiter_pick, the combinational round-robin pick (two requests + last_owner -> next state).
- The rest is a single module: state register plus output muxes.

Test Plan:
- Reset: RST_N_I=0 with M0_CYC_I=1 -> GRANT_O=00, S_CYC_O=0, M0_STALL_O=1. Release reset -> GRANT_O=01 one edge later.
- Single master: M1 reads address 0x00001234, slave ACKs after 2 cycles with 0xA5 -> M1_DAT_O=0xA5 with M1_ACK_O=1; M0_ACK_O stays 0.
- Contention from IDLE: M0 and M1 raise CYC on the same edge after reset (PRIO_M0_FIRST=1) -> OWN0 first. M0 drops CYC -> GRANT_O=10 next edge.
- No preemption: M0 holds CYC for 4-strobe burst 0x100..0x103 while M1 requests -> M1_STALL_O=1 throughout, all 4 ACKs go to M0, M1 owns 1 cycle after M0 CYC falls.
- Fairness: both masters re-request continuously for 6 cycles each -> grants alternate 01,10,01,10.
- Async reset mid-burst: RST_N_I falls between clock edges during an M1 write -> S_CYC_O/S_STB_O/S_WE_O drop before the next edge, GRANT_O=00.
